mem_access_ctrl: RTL

- Initiator-side sequencer for the 512x32 asynchronous RAM.
- Accepts single-word read/write requests from the control unit (MAR/MDR path).
- Drives the RAM read/write strobes, 9-bit address and write data with safe setup and hold, and returns read data with a done pulse.
- Sits between the MAR/MDR registers and the RAM; it is the only driver of RAM strobes.

---
 rtl/mem_access_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: initiator-side sequencer for the 512x32 asynchronous RAM.
// Takes single-word read/write requests from the MAR/MDR path, drives the RAM
// strobes, address and write data with one cycle of setup and one of hold, and
// returns read data alongside a one-cycle done pulse.
//
// Ports:
//   clock, clear          - clock and synchronous active-low reset
//   req_read, req_write   - level requests, sampled only while idle
//   addr_in, wdata_in     - word address (MAR) and write data (MDR)
//   rdata_out             - captured read data to MDR
//   busy, done, err       - status: in-flight, completion pulse, error pulse
//   ram_read, ram_write   - RAM strobes (this block is their only driver)
//   ram_address, ram_wdata- RAM address and write data
//   ram_rdata             - RAM read data, may be Z while not reading
module mem_access_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned ADDR_W      = 9
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [31:0]       addr_in,
    input  logic [31:0]       wdata_in,
    output logic [31:0]       rdata_out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_HOLD  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic               op_write;

    // Next-value nets for the registered outputs and datapath
    logic [CNT_W-1:0]   cnt_d;
    logic               op_write_d;
    logic               busy_d;
    logic               done_d;
    logic               err_d;
    logic               ram_read_d;
    logic               ram_write_d;
    logic [ADDR_W-1:0]  ram_address_d;
    logic [DATA_W-1:0]  ram_wdata_d;
    logic [DATA_W-1:0]  rdata_out_d;

    // Request qualification in IDLE
    logic req_any;
    logic req_bad;
    logic accept;
    logic read_last;

    assign req_any   = req_read | req_write;
    assign req_bad   = (req_read & req_write) | (|addr_in[DATA_W-1:ADDR_W]);
    assign accept    = (state == S_IDLE) & req_any & ~req_bad;
    assign read_last = (state == S_READ) & (cnt == '0);

    // State register
    always_ff @(posedge clock) begin
        if (!clear) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (accept) next_state = S_SETUP;
            S_SETUP: next_state = op_write ? S_WRITE : S_READ;
            S_READ:  if (cnt == '0) next_state = S_HOLD;
            S_WRITE: next_state = S_HOLD;
            S_HOLD:  next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output logic: strobes and status are decoded from the next state so that
    // the registered copies line up with the state they belong to.
    always_comb begin
        busy_d        = (next_state != S_IDLE);
        done_d        = (next_state == S_DONE);
        ram_read_d    = (next_state == S_READ);
        ram_write_d   = (next_state == S_WRITE);
        err_d         = (state == S_IDLE) & req_any & req_bad;
        op_write_d    = op_write;
        ram_address_d = ram_address;
        ram_wdata_d   = ram_wdata;
        rdata_out_d   = rdata_out;
        cnt_d         = cnt;

        if (accept) begin
            op_write_d    = req_write;
            ram_address_d = addr_in[ADDR_W-1:0];
            if (req_write) begin
                ram_wdata_d = wdata_in;
            end
        end

        // Read strobe is held for WAIT_CYCLES+1 cycles; counter loads on SETUP
        if (state == S_SETUP) begin
            cnt_d = CNT_W'(WAIT_CYCLES);
        end else if ((state == S_READ) && (cnt != '0)) begin
            cnt_d = cnt - CNT_W'(1);
        end

        // Capture only while the read strobe is high, so RAM Z is never taken
        if (read_last) begin
            rdata_out_d = ram_rdata;
        end
    end

    // Output and datapath registers
    always_ff @(posedge clock) begin
        if (!clear) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            ram_read    <= 1'b0;
            ram_write   <= 1'b0;
            ram_address <= '0;
            ram_wdata   <= '0;
            rdata_out   <= '0;
            op_write    <= 1'b0;
            cnt         <= '0;
        end else begin
            busy        <= busy_d;
            done        <= done_d;
            err         <= err_d;
            ram_read    <= ram_read_d;
            ram_write   <= ram_write_d;
            ram_address <= ram_address_d;
            ram_wdata   <= ram_wdata_d;
            rdata_out   <= rdata_out_d;
            op_write    <= op_write_d;
            cnt         <= cnt_d;
        end
    end

endmodule
